// File: rtl/conv_frame_sequencer_if.sv
// Bundle between the frame sequencer, the 3x3 conv/maxpool datapath and the frame buffer.
interface conv_frame_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              conv_rst_n;
    logic [7:0]        pixel_in;
    logic [7:0]        w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic [1:0]        operation;
    logic              paddingl;
    logic              paddingr;
    logic              stall;
    logic [19:0]       pixel_out;
    logic              out_valid;
    logic [19:0]       out_data;

    modport master (
        output rd_en, rd_addr, conv_rst_n, pixel_in,
        output w1, w2, w3, w4, w5, w6, w7, w8, w9,
        output operation, paddingl, paddingr, out_valid, out_data,
        input  rd_data, stall, pixel_out
    );

    modport slave (
        input  rd_en, rd_addr, conv_rst_n, pixel_in,
        input  w1, w2, w3, w4, w5, w6, w7, w8, w9,
        input  operation, paddingl, paddingr, out_valid, out_data,
        output rd_data, stall, pixel_out
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame controller: weight bank, pixel streaming from the frame buffer, padding/op control
// and registered result stream for the 3x3 conv / 2x2 maxpool datapath.
module conv_frame_sequencer #(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256,
    parameter int ADDR_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  logic       w_wr_en,
    input  logic [3:0] w_wr_idx,
    input  logic [7:0] w_wr_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    conv_frame_sequencer_if.master bus
);
    localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W = $clog2(NPIX) + 1;
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]        state_q;
    logic [1:0]        op_q;
    logic              err_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_vld_q;
    logic [7:0]        pix_q;
    logic              primed_q;
    logic [CNT_W-1:0]  pos_q;
    logic [ROW_W-1:0]  orow_q;
    logic [COL_W-1:0]  ocol_q;
    logic              out_vld_q;
    logic [19:0]       out_data_q;
    logic [7:0]        w_q [9];

    logic active, consume, emit, last_pos, col_last;

    always_comb begin
        active   = (state_q == RUN) || (state_q == DRAIN);
        // Positions only advance once pixel 0 is in front of the datapath.
        consume  = active && primed_q && !bus.stall;
        emit     = consume && ((op_q == 2'd0) || (orow_q[0] && ocol_q[0]));
        last_pos = (pos_q == CNT_W'(NPIX - 1));
        col_last = (ocol_q == COL_W'(IMAGE_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            err_q      <= 1'b0;
            rd_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            pix_q      <= '0;
            primed_q   <= 1'b0;
            pos_q      <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            for (int i = 0; i < 9; i++) w_q[i] <= '0;
        end else begin
            rd_vld_q  <= bus.rd_en;
            pix_q     <= rd_vld_q ? bus.rd_data : 8'd0;
            out_vld_q <= emit;
            if (emit) out_data_q <= bus.pixel_out;

            if (state_q == IDLE) primed_q <= 1'b0;
            else if (rd_vld_q)   primed_q <= 1'b1;

            if (consume) begin
                pos_q <= pos_q + 1'b1;
                if (col_last) begin
                    ocol_q <= '0;
                    orow_q <= orow_q + 1'b1;
                end else begin
                    ocol_q <= ocol_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    rd_addr_q <= '0;
                    pos_q     <= '0;
                    orow_q    <= '0;
                    ocol_q    <= '0;
                    if (w_wr_en && w_wr_idx >= 4'd1 && w_wr_idx <= 4'd9) begin
                        w_q[w_wr_idx - 4'd1] <= w_wr_data;
                    end
                    if (start) begin
                        op_q <= op_sel;
                        if (op_sel[1]) begin
                            err_q   <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    state_q   <= RUN;
                end
                RUN: begin
                    if (consume && last_pos) begin
                        state_q <= FIN;
                    end else if (rd_addr_q == ADDR_W'(NPIX - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (consume && last_pos) state_q <= FIN;
                end
                FIN: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FIN);
        err  = done && err_q;
    end

    assign bus.rd_en      = (state_q == FILL) || (state_q == RUN);
    assign bus.rd_addr    = rd_addr_q;
    assign bus.conv_rst_n = (state_q != IDLE);
    assign bus.pixel_in   = pix_q;
    assign bus.operation  = op_q;
    assign bus.paddingl   = active && (ocol_q == '0);
    assign bus.paddingr   = active && col_last;
    assign bus.out_valid  = out_vld_q;
    assign bus.out_data   = out_data_q;
    assign bus.w1 = w_q[0];
    assign bus.w2 = w_q[1];
    assign bus.w3 = w_q[2];
    assign bus.w4 = w_q[3];
    assign bus.w5 = w_q[4];
    assign bus.w6 = w_q[5];
    assign bus.w7 = w_q[6];
    assign bus.w8 = w_q[7];
    assign bus.w9 = w_q[8];
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer at 4x4 with a behavioural datapath and frame buffer.
module tb_conv_frame_sequencer;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int AW   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_sel = 2'd0;
    logic       w_wr_en = 1'b0;
    logic [3:0] w_wr_idx = 4'd0;
    logic [7:0] w_wr_data = 8'd0;
    logic       busy, done, err;

    conv_frame_sequencer_if #(.ADDR_W(AW)) bus ();

    conv_frame_sequencer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_W      (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sel   (op_sel),
        .w_wr_en  (w_wr_en),
        .w_wr_idx (w_wr_idx),
        .w_wr_data(w_wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  img [NPIX];
    int          tb_cyc = 0;
    int          tb_pos = 0;
    int          stall_len = 0;
    logic [1:0]  cur_op = 2'd0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [19:0] beats [$];

    // Frame buffer with 1-cycle read latency, plus datapath position tracking.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= img[bus.rd_addr[3:0]];
        if (!bus.conv_rst_n) begin
            tb_cyc <= 0;
            tb_pos <= 0;
        end else begin
            tb_cyc <= tb_cyc + 1;
            if (tb_cyc >= 2 && !bus.stall && tb_pos < NPIX) tb_pos <= tb_pos + 1;
        end
    end

    function automatic logic [19:0] dp_model(input int pos, input logic [1:0] op);
        int r, c, acc, v;
        acc = 0;
        if (pos >= NPIX) return 20'd0;
        r = pos / W;
        c = pos % W;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
                    v = int'(img[(r + dr) * W + c + dc]);
                    if (op == 2'd0) acc += v;
                    else if (dr <= 0 && dc <= 0 && v > acc) acc = v;
                end
            end
        end
        return 20'(acc);
    endfunction

    assign bus.stall     = (tb_cyc < 2 + stall_len);
    assign bus.pixel_out = dp_model(tb_pos, cur_op);

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wr_w(input logic [3:0] idx, input logic [7:0] data);
        w_wr_en   = 1'b1;
        w_wr_idx  = idx;
        w_wr_data = data;
        @(negedge clk);
        w_wr_en   = 1'b0;
    endtask

    function automatic logic [71:0] wbank();
        return {bus.w9, bus.w8, bus.w7, bus.w6, bus.w5, bus.w4, bus.w3, bus.w2, bus.w1};
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ctl"}, {busy, done, err, bus.rd_en, bus.out_valid, bus.paddingl,
                                 bus.paddingr, bus.conv_rst_n}, 8'd0);
        check_eq({tag, "_data"}, {bus.rd_addr, bus.out_data, bus.pixel_in, bus.operation}, 0);
        check_eq({tag, "_busy_dp"}, wbank(), 0);
    endtask

    // Runs one frame from a negedge; intrude pokes a weight write and a start mid-frame.
    task automatic run_frame(input logic [1:0] op, input int stl, input logic intrude);
        int n_rd, done_c, last_c;
        n_rd = 0; done_c = -1; last_c = -1;
        beats.delete();
        cur_op = op;
        stall_len = stl;
        start = 1'b1; op_sel = op;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && done_c < 0; c++) begin
            if (bus.rd_en) begin
                check_eq("rd_addr", bus.rd_addr, n_rd);
                n_rd++;
            end
            if (bus.out_valid) begin
                beats.push_back(bus.out_data);
                last_c = c;
            end
            if (busy && tb_cyc >= 2 && tb_pos < NPIX) begin
                check_eq("paddingl", bus.paddingl, (tb_pos % W) == 0);
                check_eq("paddingr", bus.paddingr, (tb_pos % W) == W - 1);
            end
            if (tb_cyc >= 2 && tb_cyc < NPIX + 2) check_eq("pixel_in", bus.pixel_in, img[tb_cyc - 2]);
            if (done) begin
                done_c = c;
                check_eq("err_legal", err, 1'b0);
            end
            if (intrude && c == 5) begin
                w_wr_en = 1'b1; w_wr_idx = 4'd1; w_wr_data = 8'h55;
                start = 1'b1; op_sel = 2'd3;
            end else begin
                w_wr_en = 1'b0; start = 1'b0; op_sel = op;
            end
            @(negedge clk);
        end
        check_eq("done_seen", done_c >= 0, 1'b1);
        check_eq("rd_count", n_rd, NPIX);
        check_eq("done_after_last", done_c, last_c);
        check_eq("idle_after", {busy, done, bus.rd_en}, 3'd0);
    endtask

    task automatic check_beats(input string tag, input int exp []);
        check_eq({tag, "_nbeats"}, beats.size(), exp.size());
        for (int i = 0; i < exp.size() && i < beats.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), beats[i], exp[i]);
    endtask

    initial begin
        int conv_exp [] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};
        int mp_exp []   = '{5, 7, 13, 15};
        int nd;
        for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // Abort a conv frame mid-RUN.
        cur_op = 2'd0;
        start = 1'b1; op_sel = 2'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("mid_run_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("mid_rst");
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check_eq("no_done_after_rst", nd, 0);

        run_frame(2'd1, 0, 1'b0);
        check_beats("maxpool", mp_exp);

        for (int i = 1; i <= 9; i++) wr_w(4'(i), 8'(i));
        wr_w(4'd0, 8'hFF);
        wr_w(4'd12, 8'hFF);
        check_eq("wbank_load", wbank(), 72'h09_08_07_06_05_04_03_02_01);

        for (int i = 1; i <= 9; i++) wr_w(4'(i), 8'd1);
        for (int i = 0; i < NPIX; i++) img[i] = 8'd1;
        run_frame(2'd0, 0, 1'b1);
        check_beats("conv", conv_exp);
        check_eq("wbank_busy_write", wbank(), 72'h01_01_01_01_01_01_01_01_01);
        check_eq("op_latched", bus.operation, 2'd0);

        // Illegal op: done+err without any reads.
        start = 1'b1; op_sel = 2'd3;
        @(negedge clk);
        start = 1'b0;
        check_eq("illegal_done_err", {done, err, bus.rd_en}, 3'b110);
        @(negedge clk);
        check_eq("illegal_idle", {busy, done, err, bus.rd_en}, 4'd0);

        run_frame(2'd0, 5, 1'b0);
        check_beats("stall", conv_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
